// File: rtl/branch_compare_arbiter_if.sv
// Request/response bundle between NUM_REQ branch requesters and the shared comparator.
// Requesters drive the master side; the arbiter implements the slave side.
interface branch_compare_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = 32
);
   logic [NUM_REQ-1:0]                i_req_valid;
   logic [NUM_REQ-1:0]                o_req_ready;
   logic [NUM_REQ-1:0][2:0]           i_req_funct;
   logic [NUM_REQ-1:0][DATA_SIZE-1:0] i_req_r1;
   logic [NUM_REQ-1:0][DATA_SIZE-1:0] i_req_r2;
   logic [NUM_REQ-1:0]                i_flush;
   logic [NUM_REQ-1:0]                o_rsp_valid;
   logic                              o_rsp_taken;
   logic                              o_rsp_illegal;

   modport master (
      output i_req_valid, i_req_funct, i_req_r1, i_req_r2, i_flush,
      input  o_req_ready, o_rsp_valid, o_rsp_taken, o_rsp_illegal
   );

   modport slave (
      input  i_req_valid, i_req_funct, i_req_r1, i_req_r2, i_flush,
      output o_req_ready, o_rsp_valid, o_rsp_taken, o_rsp_illegal
   );
endinterface

// File: rtl/branch_compare_arbiter.sv
// Round-robin shared branch comparator: grant -> S1 operand capture -> S2 registered result.
// Response two cycles after grant as a one-cycle pulse; ready is the only backpressure, responses cannot stall.
module branch_compare_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = 32
) (
   input logic                     i_clk,
   input logic                     i_rst,
   branch_compare_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [2:0] t_brop;
   localparam t_brop BR_EQ  = 3'b000;
   localparam t_brop BR_NE  = 3'b001;
   localparam t_brop BR_LT  = 3'b100;
   localparam t_brop BR_GE  = 3'b101;
   localparam t_brop BR_LTU = 3'b110;
   localparam t_brop BR_GEU = 3'b111;

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     ptr_next;
   logic [PTR_W-1:0]     win_id;
   logic                 win_valid;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant;

   logic                 s1_valid;
   logic [PTR_W-1:0]     s1_id;
   t_brop                s1_funct;
   logic [DATA_SIZE-1:0] s1_r1;
   logic [DATA_SIZE-1:0] s1_r2;
   logic                 s1_live;
   logic                 cmp_taken;
   logic                 cmp_illegal;

   logic [NUM_REQ-1:0]   rsp_valid;
   logic                 rsp_taken;
   logic                 rsp_illegal;

   // A flushed requester is invisible to the search, so flush beats a same-cycle grant.
   always_comb begin
      int idx;
      eligible  = bus.i_req_valid & ~bus.i_flush;
      win_valid = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!win_valid && eligible[idx]) begin
            win_valid = 1'b1;
            win_id    = PTR_W'(idx);
         end
      end
      if (i_rst) begin
         win_valid = 1'b0;
      end
      grant    = win_valid ? (NUM_REQ'(1) << win_id) : '0;
      ptr_next = (win_id == PTR_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
   end

   assign bus.o_req_ready = grant;

   always_comb begin
      cmp_taken   = 1'b0;
      cmp_illegal = 1'b0;
      case (s1_funct)
         BR_EQ:   cmp_taken = (s1_r1 == s1_r2);
         BR_NE:   cmp_taken = (s1_r1 != s1_r2);
         BR_LT:   cmp_taken = ($signed(s1_r1) <  $signed(s1_r2));
         BR_GE:   cmp_taken = ($signed(s1_r1) >= $signed(s1_r2));
         BR_LTU:  cmp_taken = (s1_r1 <  s1_r2);
         BR_GEU:  cmp_taken = (s1_r1 >= s1_r2);
         default: cmp_illegal = 1'b1;
      endcase
   end

   assign s1_live = s1_valid & ~bus.i_flush[s1_id];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr         <= '0;
         s1_valid    <= 1'b0;
         s1_id       <= '0;
         s1_funct    <= '0;
         s1_r1       <= '0;
         s1_r2       <= '0;
         rsp_valid   <= '0;
         rsp_taken   <= 1'b0;
         rsp_illegal <= 1'b0;
      end else begin
         s1_valid <= win_valid;
         if (win_valid) begin
            ptr      <= ptr_next;
            s1_id    <= win_id;
            s1_funct <= bus.i_req_funct[win_id];
            s1_r1    <= bus.i_req_r1[win_id];
            s1_r2    <= bus.i_req_r2[win_id];
         end
         rsp_valid   <= s1_live ? (NUM_REQ'(1) << s1_id) : '0;
         rsp_taken   <= s1_live & cmp_taken;
         rsp_illegal <= s1_live & cmp_illegal;
      end
   end

   assign bus.o_rsp_valid   = rsp_valid;
   assign bus.o_rsp_taken   = rsp_taken;
   assign bus.o_rsp_illegal = rsp_illegal;
endmodule

// File: tb/tb_branch_compare_arbiter.sv
// Bench for branch_compare_arbiter: directed scenarios plus random traffic, scored against
// a queue-based reference of round-robin grants and RISC-V branch semantics.
module tb_branch_compare_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   bit clk;
   logic rst;
   int cyc;
   int checks;
   int failures;

   branch_compare_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(W)) bus ();

   branch_compare_arbiter #(.NUM_REQ(N), .DATA_SIZE(W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int id;
      bit taken;
      bit illegal;
      int due;
   } exp_t;

   exp_t sbq[$];

   // Requester-side state: a pending request is held until granted.
   logic [N-1:0]        pend;
   logic [N-1:0][2:0]   pf;
   logic [N-1:0][W-1:0] pa;
   logic [N-1:0][W-1:0] pb;
   logic [N-1:0]        flush_v;
   logic                rst_v;

   // Reference state.
   int   mptr;
   bit   s1_has;
   exp_t s1_ent;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void ref_branch(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output bit t, output bit il);
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      t  = 0;
      il = 0;
      case (f)
         3'd0: t = (ua == ub);
         3'd1: t = (ua != ub);
         3'd4: t = (sa < sb);
         3'd5: t = (sa >= sb);
         3'd6: t = (ua < ub);
         3'd7: t = (ua >= ub);
         default: il = 1;
      endcase
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] picks [5];
      picks[0] = 32'h0000_0000;
      picks[1] = 32'h0000_0001;
      picks[2] = 32'hFFFF_FFFF;
      picks[3] = 32'h8000_0000;
      picks[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 2) == 0) return picks[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic set_req(input int k, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      pend[k] = 1'b1;
      pf[k]   = f;
      pa[k]   = a;
      pb[k]   = b;
   endtask

   // One clock cycle: drive, compare the grant with the reference, advance the reference.
   task automatic step();
      int   w;
      logic [N-1:0] exp_grant;
      exp_t e;
      @(negedge clk);
      bus.i_req_valid = pend;
      bus.i_req_funct = pf;
      bus.i_req_r1    = pa;
      bus.i_req_r2    = pb;
      bus.i_flush     = flush_v;
      rst             = rst_v;
      #1;
      w = -1;
      if (!rst_v) begin
         for (int i = 0; i < N; i++) begin
            int idx;
            idx = (mptr + i) % N;
            if (w < 0 && pend[idx] && !flush_v[idx]) w = idx;
         end
      end
      exp_grant = '0;
      if (w >= 0) exp_grant[w] = 1'b1;
      chk("req_ready", 64'(bus.o_req_ready), 64'(exp_grant));
      // Entry granted last cycle survives into the response register unless flushed or reset now.
      if (s1_has && !rst_v && !flush_v[s1_ent.id]) begin
         s1_ent.due = cyc + 1;
         sbq.push_back(s1_ent);
      end
      s1_has = (w >= 0);
      if (w >= 0) begin
         e.id = w;
         ref_branch(pf[w], pa[w], pb[w], e.taken, e.illegal);
         e.due  = 0;
         s1_ent = e;
         pend[w] = 1'b0;
         mptr = (w + 1) % N;
      end
      if (rst_v) mptr = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Response monitor, independent of the stimulus process.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.o_rsp_valid != '0) begin
            if (sbq.size() == 0) begin
               chk("rsp_unexpected", 64'(bus.o_rsp_valid), 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("rsp_valid_id", 64'(bus.o_rsp_valid), 64'(1) << e.id);
               chk("rsp_taken",    64'(bus.o_rsp_taken), 64'(e.taken));
               chk("rsp_illegal",  64'(bus.o_rsp_illegal), 64'(e.illegal));
            end
         end else begin
            chk("rsp_idle_zero", 64'({bus.o_rsp_taken, bus.o_rsp_illegal}), 64'd0);
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
               e = sbq.pop_front();
               chk("rsp_missing", 64'(bus.o_rsp_valid), 64'(1) << e.id);
            end
         end
      end
   end

   initial begin
      pend = '0; pf = '0; pa = '0; pb = '0; flush_v = '0; rst_v = 1'b1;
      mptr = 0; s1_has = 0; checks = 0; failures = 0;
      rst = 1'b1;
      bus.i_req_valid = '0; bus.i_req_funct = '0; bus.i_req_r1 = '0; bus.i_req_r2 = '0; bus.i_flush = '0;

      idle(2);
      rst_v = 1'b0;
      chk("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);

      // Single requester: BLT then BLTU of -1 vs 1.
      set_req(1, 3'b100, 32'hFFFF_FFFF, 32'h1);
      idle(3);
      set_req(1, 3'b110, 32'hFFFF_FFFF, 32'h1);
      idle(3);

      // All requesters valid; reset lands mid-stream, then the order restarts at 0.
      for (int c = 0; c < 5; c++) begin
         for (int k = 0; k < N; k++) if (!pend[k]) set_req(k, 3'($urandom_range(0, 7)), rand_op(), rand_op());
         step();
      end
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < N; k++) if (!pend[k]) set_req(k, 3'($urandom_range(0, 7)), rand_op(), rand_op());
         step();
      end
      idle(6);

      // Illegal funct, then BEQ on equal operands.
      set_req(0, 3'b010, 32'd5, 32'd5);
      step();
      set_req(0, 3'b000, 32'd5, 32'd5);
      idle(3);

      // Flush one cycle after grant, then flush colliding with valid.
      set_req(2, 3'b000, 32'd9, 32'd9);
      step();
      flush_v = 4'b0100;
      step();
      flush_v = '0;
      idle(2);
      set_req(2, 3'b001, 32'd1, 32'd2);
      set_req(3, 3'b111, 32'd3, 32'd2);
      flush_v = 4'b0100;
      step();
      flush_v = '0;
      idle(4);

      // Pointer wrap: req3 alone, then req0 alone.
      set_req(3, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      set_req(0, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(4);

      // Random traffic with occasional flush and reset.
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 2) != 0)
               set_req(k, 3'($urandom_range(0, 7)), rand_op(), rand_op());
            flush_v[k] = ($urandom_range(0, 15) == 0);
         end
         rst_v = ($urandom_range(0, 99) == 0);
         step();
      end
      flush_v = '0;
      rst_v   = 1'b0;
      idle(12);
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
      chk("requests_drained",   64'(pend), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_compare_arbiter.md
# branch_compare_arbiter

Shares one branch comparator among `NUM_REQ` requesters, such as per-core branch units in the multicore build. Each cycle a round-robin arbiter selects one valid request and registers its operands. The shared comparator resolves the request, and the block returns a registered taken/not-taken result to the winning requester. Arbitration, operand staging, per-requester flush and illegal-funct reporting are all handled here; requesters see a simple valid/ready request and a one-cycle response pulse.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_SIZE`, default from `multicore_pkg` (32): operand width.

Ports:
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `i_req_valid`, in, `NUM_REQ`: request valid, one bit per requester.
- `o_req_ready`, out, `NUM_REQ`: one-hot grant. Combinational from `i_req_valid`, the pointer and `i_rst`.
- `i_req_funct`, in, `NUM_REQ`x3 (`t_brop`): branch funct3 per requester.
- `i_req_r1`, in, `NUM_REQ`x`DATA_SIZE`: first operand per requester.
- `i_req_r2`, in, `NUM_REQ`x`DATA_SIZE`: second operand per requester.
- `i_flush`, in, `NUM_REQ`: cancel any in-flight request of requester k.
- `o_rsp_valid`, out, `NUM_REQ`: one-hot response pulse.
- `o_rsp_taken`, out, 1: branch outcome. Meaningful only when `o_rsp_valid` is nonzero.
- `o_rsp_illegal`, out, 1: funct was not a defined branch code.

## Operation
Arbitration:
- Round-robin pointer `ptr` (log2 `NUM_REQ` bits); reset value 0.
- Search order is `ptr`, `ptr+1`, … modulo `NUM_REQ`; the first valid requester wins.
- `o_req_ready` = one-hot of the winner; all zeros if no request is valid or `i_rst` is high.
- On a grant, `ptr` ← winner+1, wrapping from `NUM_REQ-1` to 0. With no grant, `ptr` holds.
- Requesters hold valid, funct and operands stable until ready is seen. Valid must not be deasserted before grant.

Stage S1 (capture):
- On a grant, register `s1_valid`=1, `s1_id`=winner, and the winner's funct, r1 and r2.
- Otherwise `s1_valid`=0.

Compare (combinational on S1 registers):
- 000 taken = r1==r2
- 001 taken = r1!=r2
- 100 taken = signed r1<r2
- 101 taken = signed r1>=r2
- 110 taken = unsigned r1<r2
- 111 taken = unsigned r1>=r2
- 010 or 011: taken=0, illegal=1.

Stage S2 (response register):
- `o_rsp_valid` = onehot(`s1_id`) when `s1_valid`, else 0.
- `o_rsp_taken` and `o_rsp_illegal` are registered from the compare.
- Taken and illegal are forced to 0 when no response is issued.

Flush:
- `i_flush[k]` in any cycle clears an S1 entry whose id is k, so no S2 response is produced.
- It also masks requester k from arbitration in that cycle (ready[k]=0).
- It does not affect an S2 response already on the outputs.

Reset:
- All registers clear: `ptr`=0, `s1_valid`=0, all `o_rsp_*`=0. `o_req_ready`=0 while `i_rst` is high.
- Reset mid-operation discards S1 and S2 contents; no response is emitted for them.

## Timing
- Throughput: one request per cycle across all requesters.
- Latency: a request granted in cycle T (valid&ready high before edge T) has its response visible in cycle T+2, i.e. after the second rising edge.
- The response pulse is exactly one cycle; there is no response back-pressure.
- Simultaneous grant, S1 and S2 activity for different requests in the same cycle is normal pipelined operation.
- A requester may be re-granted while its previous request is still in S1; responses return in grant order.
- Flush in the same cycle as a grant to the same requester: flush wins. There is no grant, and ptr does not advance for that requester.
- Fairness: with all requesters continuously valid, each is granted exactly once per `NUM_REQ` cycles.

## Test plan
- **Reset:** assert `i_rst` mid-stream with requests in S1 and S2. Required: the next cycle has `o_rsp_valid`=0 and `o_req_ready`=0; the first grant after release goes to requester 0.
- **Single requester:** req1 BLT, r1=0xFFFFFFFF, r2=1. Required: ready[1] in cycle T; `o_rsp_valid`=0010 with taken=1 at T+2. Repeat with BLTU: taken=0.
- **All valid, NUM_REQ=4, for 8 cycles:** required grant order 0,1,2,3,0,1,2,3. Responses follow 2 cycles behind with matching ids.
- **Illegal funct:** funct=010, r1=r2=5. Required: taken=0 and illegal=1 at T+2. Then BEQ with 5,5 gives taken=1, illegal=0.
- **Flush:** req2 granted at T, `i_flush[2]` at T+1. Required: no response at T+2. Flush raised together with valid[2] gives ready[2]=0 and the grant passes to the next valid requester.
- **Pointer wrap:** only req3 valid, then only req0 valid. Required: ptr wraps to 0, req0 is granted immediately, and both responses are correct (BGE of -1 vs -1 gives taken=1).
